// File: rtl/suma_rtc_pkg.sv
// Shared types, BCD limits and load validation for the suma_rtc clock.
package suma_rtc_pkg;

   localparam int unsigned BCD_W   = 8;
   localparam int unsigned CAMPO_W = 2;

   localparam logic [BCD_W-1:0] MAX_HORA = 8'h23;
   localparam logic [BCD_W-1:0] MAX_MIN  = 8'h59;
   localparam logic [BCD_W-1:0] MAX_SEG  = 8'h59;

   // Encoding doubles as the campo_out value
   typedef enum logic [CAMPO_W-1:0] {
      CORRER    = 2'd0,
      EDIT_HORA = 2'd1,
      EDIT_MIN  = 2'd2,
      EDIT_SEG  = 2'd3
   } estado_t;

   typedef struct packed {
      logic [BCD_W-1:0] hora;
      logic [BCD_W-1:0] minuto;
      logic [BCD_W-1:0] segundo;
   } tiempo_t;

   // Both digits decimal and value not above the field limit; on valid BCD a
   // plain binary compare orders the same way as the decimal value
   function automatic logic bcd_valido(input logic [BCD_W-1:0] valor,
                                       input logic [BCD_W-1:0] maximo);
      return (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9) && (valor <= maximo);
   endfunction

endpackage

// File: rtl/suma_rtc_bcd_campo.sv
// Stateless two-digit BCD up/down step with wrap at a parameterised maximum.
module bcd_campo_mod
   import suma_rtc_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = 8'h59
) (
   input  logic [BCD_W-1:0] valor,
   input  logic             up,
   input  logic             down,
   output logic [BCD_W-1:0] siguiente_c,
   output logic             wrap_c
);

   // Step one count; simultaneous up and down cancel to a pass-through
   always_comb begin
      siguiente_c = valor;
      wrap_c      = 1'b0;
      if (up && !down) begin
         if (valor == MAX) begin
            siguiente_c = 8'h00;
            wrap_c      = 1'b1;
         end else if (valor[3:0] == 4'd9) begin
            siguiente_c = {valor[7:4] + 4'd1, 4'd0};
         end else begin
            siguiente_c = {valor[7:4], valor[3:0] + 4'd1};
         end
      end else if (down && !up) begin
         if (valor == 8'h00) begin
            siguiente_c = MAX;
            wrap_c      = 1'b1;
         end else if (valor[3:0] == 4'd0) begin
            siguiente_c = {valor[7:4] - 4'd1, 4'd9};
         end else begin
            siguiente_c = {valor[7:4], valor[3:0] - 4'd1};
         end
      end
   end

endmodule

// File: rtl/suma_rtc.sv
// BCD real-time clock: HH:MM:SS counting on a 1 Hz tick with field editing.
module suma_rtc
   import suma_rtc_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               tick_1hz,
   input  logic               load,
   input  logic [BCD_W-1:0]   hora_in,
   input  logic [BCD_W-1:0]   minuto_in,
   input  logic [BCD_W-1:0]   segundo_in,
   input  logic               btn_sig,
   input  logic               btn_arriba,
   input  logic               btn_abajo,
   output logic [BCD_W-1:0]   hora_out,
   output logic [BCD_W-1:0]   minuto_out,
   output logic [BCD_W-1:0]   segundo_out,
   output logic [CAMPO_W-1:0] campo_out,
   output logic               acarreo_dia,
   output logic               error_carga
);

   estado_t estado, estado_sig;
   tiempo_t tiempo, tiempo_sig;
   logic    acarreo_sig, error_sig;

   logic avanza, ajuste;
   logic seg_up, seg_dn, min_up, min_dn, hora_up, hora_dn;
   logic seg_wrap, min_wrap, hora_wrap;
   logic [BCD_W-1:0] seg_nx, min_nx, hora_nx;

   // Event qualification: load and btn_sig pre-empt adjust and tick
   always_comb begin
      avanza  = (estado == CORRER) && tick_1hz && !load && !btn_sig;
      ajuste  = (estado != CORRER) && (btn_arriba ^ btn_abajo) && !load && !btn_sig;
      seg_up  = avanza || (ajuste && btn_arriba && (estado == EDIT_SEG));
      seg_dn  = ajuste && btn_abajo && (estado == EDIT_SEG);
      min_up  = (avanza && seg_wrap) || (ajuste && btn_arriba && (estado == EDIT_MIN));
      min_dn  = ajuste && btn_abajo && (estado == EDIT_MIN);
      hora_up = (avanza && seg_wrap && min_wrap) ||
                (ajuste && btn_arriba && (estado == EDIT_HORA));
      hora_dn = ajuste && btn_abajo && (estado == EDIT_HORA);
   end

   bcd_campo_mod #(.MAX(MAX_SEG)) u_seg (
      .valor       (tiempo.segundo),
      .up          (seg_up),
      .down        (seg_dn),
      .siguiente_c (seg_nx),
      .wrap_c      (seg_wrap)
   );

   bcd_campo_mod #(.MAX(MAX_MIN)) u_min (
      .valor       (tiempo.minuto),
      .up          (min_up),
      .down        (min_dn),
      .siguiente_c (min_nx),
      .wrap_c      (min_wrap)
   );

   bcd_campo_mod #(.MAX(MAX_HORA)) u_hora (
      .valor       (tiempo.hora),
      .up          (hora_up),
      .down        (hora_dn),
      .siguiente_c (hora_nx),
      .wrap_c      (hora_wrap)
   );

   // Next state, next time and pulse outputs in priority order
   always_comb begin
      estado_sig  = estado;
      tiempo_sig  = tiempo;
      acarreo_sig = 1'b0;
      error_sig   = 1'b0;
      if (load) begin
         if (bcd_valido(hora_in, MAX_HORA) && bcd_valido(minuto_in, MAX_MIN) &&
             bcd_valido(segundo_in, MAX_SEG)) begin
            tiempo_sig = '{hora: hora_in, minuto: minuto_in, segundo: segundo_in};
         end else begin
            error_sig = 1'b1;
         end
      end else if (btn_sig) begin
         unique case (estado)
            CORRER:    estado_sig = EDIT_HORA;
            EDIT_HORA: estado_sig = EDIT_MIN;
            EDIT_MIN:  estado_sig = EDIT_SEG;
            EDIT_SEG:  estado_sig = CORRER;
            default:   estado_sig = CORRER;
         endcase
      end else begin
         tiempo_sig  = '{hora: hora_nx, minuto: min_nx, segundo: seg_nx};
         acarreo_sig = avanza && seg_wrap && min_wrap && hora_wrap;
      end
   end

   // State, time and pulse registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         estado      <= CORRER;
         tiempo      <= '0;
         acarreo_dia <= 1'b0;
         error_carga <= 1'b0;
      end else begin
         estado      <= estado_sig;
         tiempo      <= tiempo_sig;
         acarreo_dia <= acarreo_sig;
         error_carga <= error_sig;
      end
   end

   assign hora_out    = tiempo.hora;
   assign minuto_out  = tiempo.minuto;
   assign segundo_out = tiempo.segundo;
   assign campo_out   = CAMPO_W'(estado);

endmodule

// File: tb/tb_suma_rtc.sv
// Directed self-checking bench for suma_rtc.
module tb_suma_rtc;

   logic       clk = 1'b0;
   logic       reset, tick_1hz, load, btn_sig, btn_arriba, btn_abajo;
   logic [7:0] hora_in, minuto_in, segundo_in;
   logic [7:0] hora_out, minuto_out, segundo_out;
   logic [1:0] campo_out;
   logic       acarreo_dia, error_carga;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   suma_rtc dut (
      .clk         (clk),
      .reset       (reset),
      .tick_1hz    (tick_1hz),
      .load        (load),
      .hora_in     (hora_in),
      .minuto_in   (minuto_in),
      .segundo_in  (segundo_in),
      .btn_sig     (btn_sig),
      .btn_arriba  (btn_arriba),
      .btn_abajo   (btn_abajo),
      .hora_out    (hora_out),
      .minuto_out  (minuto_out),
      .segundo_out (segundo_out),
      .campo_out   (campo_out),
      .acarreo_dia (acarreo_dia),
      .error_carga (error_carga)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_time(input string tag, input logic [23:0] exp);
      check(tag, {8'h00, hora_out, minuto_out, segundo_out}, {8'h00, exp});
   endtask

   // Apply the currently driven inputs for one edge, sample after it, clear pulses
   task automatic cycle();
      @(posedge clk);
      #1;
      reset = 0; tick_1hz = 0; load = 0; btn_sig = 0; btn_arriba = 0; btn_abajo = 0;
   endtask

   task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      load = 1; hora_in = h; minuto_in = m; segundo_in = s;
   endtask

   initial begin
      reset = 1; tick_1hz = 0; load = 0; btn_sig = 0; btn_arriba = 0; btn_abajo = 0;
      hora_in = 0; minuto_in = 0; segundo_in = 0;
      cycle();
      reset = 1; cycle();
      check_time("reset_time", 24'h000000);
      check("reset_campo", 32'(campo_out), 32'd0);
      check("reset_acarreo", 32'(acarreo_dia), 32'd0);
      check("reset_error", 32'(error_carga), 32'd0);

      // Day rollover
      set_load(8'h23, 8'h59, 8'h58); cycle();
      check_time("load_235958", 24'h235958);
      tick_1hz = 1; cycle();
      check_time("tick_235959", 24'h235959);
      check("no_acarreo_59", 32'(acarreo_dia), 32'd0);
      tick_1hz = 1; cycle();
      check_time("tick_rollover", 24'h000000);
      check("acarreo_pulse", 32'(acarreo_dia), 32'd1);
      cycle();
      check("acarreo_one_cycle", 32'(acarreo_dia), 32'd0);

      // Seconds-to-minutes carry
      set_load(8'h12, 8'h09, 8'h59); cycle();
      tick_1hz = 1; cycle();
      check_time("tick_121000", 24'h121000);
      check("no_acarreo_min", 32'(acarreo_dia), 32'd0);

      // Adjust ignored while running
      btn_arriba = 1; cycle();
      check_time("adjust_in_correr", 24'h121000);

      // Rejected loads
      set_load(8'h24, 8'h00, 8'h00); cycle();
      check("err_hora24", 32'(error_carga), 32'd1);
      check_time("err_hora24_time", 24'h121000);
      cycle();
      check("err_one_cycle", 32'(error_carga), 32'd0);
      set_load(8'h00, 8'h5A, 8'h00); cycle();
      check("err_min5a", 32'(error_carga), 32'd1);
      check_time("err_min5a_time", 24'h121000);
      set_load(8'h00, 8'h00, 8'h60); cycle();
      check("err_seg60", 32'(error_carga), 32'd1);

      // Editing from midnight
      reset = 1; cycle();
      btn_sig = 1; cycle();
      check("campo_hora", 32'(campo_out), 32'd1);
      btn_abajo = 1; cycle();
      check_time("hora_down_wrap", 24'h230000);
      tick_1hz = 1; cycle();
      check_time("tick_ignored_edit", 24'h230000);
      btn_arriba = 1; btn_abajo = 1; cycle();
      check_time("up_down_cancel", 24'h230000);
      btn_arriba = 1; cycle();
      check_time("hora_up_wrap", 24'h000000);
      btn_abajo = 1; cycle();
      btn_sig = 1; cycle();
      check("campo_min", 32'(campo_out), 32'd2);
      for (int i = 0; i < 59; i++) begin
         btn_arriba = 1; tick_1hz = (i % 7 == 0); cycle();
      end
      check_time("min_up_59", 24'h235900);
      btn_arriba = 1; cycle();
      check_time("min_up_60_wrap", 24'h230000);
      btn_abajo = 1; cycle();
      check_time("min_down_wrap", 24'h235900);
      btn_sig = 1; cycle();
      check("campo_seg", 32'(campo_out), 32'd3);
      set_load(8'h05, 8'h30, 8'h59); cycle();
      check("load_keeps_state", 32'(campo_out), 32'd3);
      btn_arriba = 1; cycle();
      check_time("seg_up_no_carry", 24'h053000);
      btn_sig = 1; cycle();
      check("campo_back_correr", 32'(campo_out), 32'd0);

      // Load beats btn_sig and tick in the same cycle
      set_load(8'h05, 8'h30, 8'h15); cycle();
      set_load(8'h07, 8'h00, 8'h00); btn_sig = 1; tick_1hz = 1; cycle();
      check_time("prio_load", 24'h070000);
      check("prio_state", 32'(campo_out), 32'd0);

      // btn_sig beats tick
      btn_sig = 1; tick_1hz = 1; cycle();
      check_time("prio_sig_time", 24'h070000);
      check("prio_sig_state", 32'(campo_out), 32'd1);

      // Reset in the middle of an edit
      btn_sig = 1; cycle();
      btn_sig = 1; cycle();
      set_load(8'h05, 8'h30, 8'h15); cycle();
      check_time("edit_seg_time", 24'h053015);
      check("edit_seg_state", 32'(campo_out), 32'd3);
      reset = 1; btn_arriba = 1; cycle();
      check_time("reset_mid_edit", 24'h000000);
      check("reset_mid_campo", 32'(campo_out), 32'd0);
      tick_1hz = 1; cycle();
      check_time("tick_after_reset", 24'h000001);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
